prog_loader: RTL and testbench

- Boot-time controller for the program RAM and the shared UART buffers.
- After reset it owns the UART RX/TX buffers. It receives a length-prefixed program image, writes it word by word into the program RAM, then sends an acknowledge byte.
- On success it asserts run, which releases the core, and hands the UART buffer handshakes to the core through an internal mux.
- Sits between the UART buffers, the program RAM write port and the core's UART ports.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_byte_assembler.sv | 34 +++
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states, ack codes and helpers for the boot-time program loader
package prog_loader_pkg;

  localparam int IDX_W = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_LEN   = 3'd0;
  localparam state_t ST_DATA  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_CHK   = 3'd3;
  localparam state_t ST_ACK   = 3'd4;
  localparam state_t ST_RUN   = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'h55;

  function automatic logic [7:0] ack_byte(input logic fail);
    return fail ? ACK_ERR : ACK_OK;
  endfunction

  // States in which the loader pops bytes from the RX buffer.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// rtl/prog_loader_byte_assembler.sv - little-endian byte-to-word assembler with 2-bit index
module byte_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      low;

  // The fourth byte is combined combinationally so the word is usable in the strobe cycle.
  assign word      = {byte_in, low};
  assign word_done = strobe && (idx == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      low <= '0;
    end else if (clear) begin
      idx <= '0;
      low <= '0;
    end else if (strobe) begin
      idx <= IDX_W'(idx + 1);
      low <= {byte_in, low[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: length-prefixed image from UART into program RAM, then releases core
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rdata,
  input  logic           rx_ready,
  output logic           next,
  output logic [7:0]     sdata,
  output logic           tx_we,
  output logic           pwe,
  output logic [MEM-3:0] paddr,
  output logic [31:0]    pdata,
  output logic           run,
  output logic           err,
  input  logic           core_next,
  input  logic [7:0]     core_sdata,
  input  logic           core_tx_we
);

  localparam int          AW  = MEM - 2;
  localparam logic [32:0] CAP = 33'd1 << AW;

  state_t        state;
  logic          next_q;
  logic          tx_we_q;
  logic          pwe_q;
  logic          run_q;
  logic          err_q;
  logic          ovf;
  logic [7:0]    byte_q;
  logic [7:0]    sdata_q;
  logic [AW-1:0] addr;
  logic [AW-1:0] paddr_q;
  logic [31:0]   pdata_q;
  logic [31:0]   word_q;
  logic [31:0]   len_q;
  logic [31:0]   count;
  logic          take;
  logic          load_bad;
  logic [31:0]   asm_word;
  logic          asm_done;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       chk_fail;
  assign load_bad = ovf | chk_fail;
`else
  assign load_bad = ovf;
`endif

  // A pop is never issued in the cycle right after a pop, so rx_ready has time to refresh.
  assign take = is_rx_state(state) && rx_ready && !next_q;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .strobe    (next_q && (state != ST_CHK)),
    .clear     (state == ST_ACK),
    .byte_in   (byte_q),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LEN;
      next_q  <= 1'b0;
      tx_we_q <= 1'b0;
      pwe_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf     <= 1'b0;
      byte_q  <= '0;
      sdata_q <= '0;
      addr    <= '0;
      paddr_q <= '0;
      pdata_q <= '0;
      word_q  <= '0;
      len_q   <= '0;
      count   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc      <= '0;
      chk_fail <= 1'b0;
`endif
    end else begin
      next_q  <= take;
      pwe_q   <= 1'b0;
      tx_we_q <= 1'b0;
      run_q   <= (state == ST_RUN);
      if (take) begin
        byte_q <= rdata;
      end
      case (state)
        ST_LEN: begin
          if (asm_done) begin
            len_q <= asm_word;
            if (asm_word == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_ACK;
`endif
            end else begin
              if ({1'b0, asm_word} > CAP) begin
                ovf <= 1'b1;
              end
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (next_q) begin
            acc <= acc ^ byte_q;
          end
`endif
          if (asm_done) begin
            word_q <= asm_word;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Overflowed images are drained but never written, so addr cannot wrap onto live words.
          if (!ovf) begin
            pwe_q   <= 1'b1;
            paddr_q <= addr;
            pdata_q <= word_q;
          end
          addr  <= AW'(addr + 1);
          count <= count + 32'd1;
          if ((count + 32'd1) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= ST_CHK;
`else
            state <= ST_ACK;
`endif
          end else begin
            state <= ST_DATA;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (next_q) begin
            if (byte_q != acc) begin
              chk_fail <= 1'b1;
            end
            state <= ST_ACK;
          end
        end
`endif
        ST_ACK: begin
          tx_we_q <= 1'b1;
          sdata_q <= ack_byte(load_bad);
          if (load_bad) begin
            err_q <= 1'b1;
            state <= ST_ERROR;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN:   state <= ST_RUN;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_LEN;
      endcase
    end
  end

  // Once released, the core owns the UART buffer handshakes.
  assign next  = run_q ? core_next  : next_q;
  assign sdata = run_q ? core_sdata : sdata_q;
  assign tx_we = run_q ? core_tx_we : tx_we_q;

  assign pwe   = pwe_q;
  assign paddr = paddr_q;
  assign pdata = pdata_q;
  assign run   = run_q;
  assign err   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader (MEM=10 and MEM=4 instances)
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rx_ready = 1'b0;
  logic        core_next = 1'b0;
  logic        core_tx_we = 1'b0;
  logic [7:0]  core_sdata = 8'h00;

  logic        next_a, tx_we_a, pwe_a, run_a, err_a;
  logic [7:0]  sdata_a;
  logic [7:0]  paddr_a;
  logic [31:0] pdata_a;
  logic        next_b, tx_we_b, pwe_b, run_b, err_b;
  logic [7:0]  sdata_b;
  logic [1:0]  paddr_b;
  logic [31:0] pdata_b;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  prog_loader #(.MEM(10)) dut_a (
    .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .next(next_a),
    .sdata(sdata_a), .tx_we(tx_we_a), .pwe(pwe_a), .paddr(paddr_a), .pdata(pdata_a),
    .run(run_a), .err(err_a), .core_next(core_next), .core_sdata(core_sdata),
    .core_tx_we(core_tx_we)
  );

  prog_loader #(.MEM(4)) dut_b (
    .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .next(next_b),
    .sdata(sdata_b), .tx_we(tx_we_b), .pwe(pwe_b), .paddr(paddr_b), .pdata(pdata_b),
    .run(run_b), .err(err_b), .core_next(core_next), .core_sdata(core_sdata),
    .core_tx_we(core_tx_we)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  rdummy;
  logic [7:0]  csum;
  logic        use_b = 1'b0;
  logic        prev_next = 1'b0;
  int          pops = 0;
  int          dbl = 0;
  int          cyc = 0;
  int          wa_n = 0;
  logic [7:0]  wa_addr[16];
  logic [31:0] wa_data[16];
  int          ack_a_n = 0;
  logic [7:0]  ack_a_byte;
  int          ack_a_cyc = 0;
  int          run_a_cyc = -1;
  int          wb_n = 0;
  int          ack_b_n = 0;
  logic [7:0]  ack_b_byte;

  wire next_sel = use_b ? next_b : next_a;

  always @(posedge clk) cyc++;

  // RX buffer model plus output logging, evaluated away from the active edge.
  always @(negedge clk) begin
    if (next_sel && prev_next) dbl++;
    prev_next = next_sel;
    if (pwe_a) begin
      if (wa_n < 16) begin
        wa_addr[wa_n] = paddr_a;
        wa_data[wa_n] = pdata_a;
      end
      wa_n++;
    end
    if (tx_we_a && !run_a) begin
      ack_a_n++;
      ack_a_byte = sdata_a;
      ack_a_cyc  = cyc;
    end
    if (run_a && run_a_cyc < 0) run_a_cyc = cyc;
    if (pwe_b) wb_n++;
    if (tx_we_b && !run_b) begin
      ack_b_n++;
      ack_b_byte = sdata_b;
    end
    if (next_sel && rxq.size() > 0) begin
      rdummy = rxq.pop_front();
      pops++;
    end
    rx_ready = (rxq.size() > 0);
    rdata    = rx_ready ? rxq[0] : 8'h00;
  end

  task automatic do_reset;
    rst = 1'b1;
    rxq.delete();
    use_b = 1'b0;
    repeat (2) @(negedge clk);
    pops = 0; dbl = 0; prev_next = 1'b0; wa_n = 0; ack_a_n = 0; run_a_cyc = -1;
    wb_n = 0; ack_b_n = 0; csum = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) rxq.push_back(n[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      rxq.push_back(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
    end
  endtask

  task automatic finish_image;
`ifdef PROG_LOADER_CHECKSUM_EN
    rxq.push_back(csum);
`endif
  endtask

  task automatic wait_ack(input logic sel_b, input string name);
    int n;
    for (n = 0; n < 3000 && ((sel_b ? ack_b_n : ack_a_n) == 0); n++) @(negedge clk);
    if ((sel_b ? ack_b_n : ack_a_n) == 0) begin
      checks++; errors++;
      $display("FAIL %s: no ack within %0d cycles, required 1 ack", name, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxq.push_back(8'h12);
    core_next = 1'b1; core_tx_we = 1'b1; core_sdata = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({next_a, tx_we_a, pwe_a, run_a, err_a} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b required 00000", {next_a, tx_we_a, pwe_a, run_a, err_a});
    end
    checks++;
    if (paddr_a !== 8'h00 || pdata_a !== 32'h0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h required 00/00000000", paddr_a, pdata_a);
    end
    checks++;
    if (sdata_a !== 8'h00) begin
      errors++; $display("FAIL reset_sdata: got %h required 00", sdata_a);
    end
    checks++;
    if ({next_b, tx_we_b, pwe_b, run_b, err_b} !== 5'b0 || paddr_b !== 2'b0) begin
      errors++; $display("FAIL reset_b: got %b/%b required 00000/00", {next_b, tx_we_b, pwe_b, run_b, err_b}, paddr_b);
    end
    core_next = 1'b0; core_tx_we = 1'b0; core_sdata = 8'h00;
  endtask

  task automatic test_load4;
    logic [31:0] exp_w[4];
    exp_w[0] = 32'h11223344; exp_w[1] = 32'h11223344; exp_w[2] = 32'h11223344; exp_w[3] = 32'hDEADBEEF;
    do_reset();
    push_len(32'd4);
    for (int i = 0; i < 4; i++) push_word(exp_w[i]);
    finish_image();
    wait_ack(1'b0, "load4_ack");
    checks++;
    if (wa_n !== 4) begin errors++; $display("FAIL load4_pwe_count: got %0d required 4", wa_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wa_addr[i] !== 8'(i) || wa_data[i] !== exp_w[i]) begin
        errors++; $display("FAIL load4_write%0d: got %h/%h required %h/%h", i, wa_addr[i], wa_data[i], 8'(i), exp_w[i]);
      end
    end
    checks++;
    if (ack_a_n !== 1 || ack_a_byte !== 8'hAA) begin
      errors++; $display("FAIL load4_ack: got n=%0d byte=%h required n=1 byte=aa", ack_a_n, ack_a_byte);
    end
    checks++;
    if (run_a_cyc !== ack_a_cyc + 1) begin
      errors++; $display("FAIL load4_run_timing: got run at %0d required %0d", run_a_cyc, ack_a_cyc + 1);
    end
    checks++;
    if (run_a !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL load4_run_err: got %b%b required 10", run_a, err_a);
    end
    checks++;
    if (pops !== 20 + CS) begin errors++; $display("FAIL load4_pops: got %0d required %0d", pops, 20 + CS); end
  endtask

  task automatic test_zero_len;
    do_reset();
    push_len(32'd0);
    finish_image();
    wait_ack(1'b0, "zero_ack");
    checks++;
    if (wa_n !== 0) begin errors++; $display("FAIL zero_pwe_count: got %0d required 0", wa_n); end
    checks++;
    if (ack_a_byte !== 8'hAA || run_a !== 1'b1) begin
      errors++; $display("FAIL zero_ack_run: got %h/%b required aa/1", ack_a_byte, run_a);
    end
  endtask

  task automatic test_overflow;
    int p;
    do_reset();
    use_b = 1'b1;
    push_len(32'd5);
    for (int i = 0; i < 5; i++) push_word(32'h01010101 * (i + 1));
    finish_image();
    wait_ack(1'b1, "ovf_ack");
    checks++;
    if (wb_n !== 0) begin errors++; $display("FAIL ovf_pwe_count: got %0d required 0", wb_n); end
    checks++;
    if (pops !== 24 + CS) begin errors++; $display("FAIL ovf_pops: got %0d required %0d", pops, 24 + CS); end
    checks++;
    if (ack_b_n !== 1 || ack_b_byte !== 8'h55) begin
      errors++; $display("FAIL ovf_ack: got n=%0d byte=%h required n=1 byte=55", ack_b_n, ack_b_byte);
    end
    checks++;
    if (err_b !== 1'b1 || run_b !== 1'b0) begin
      errors++; $display("FAIL ovf_err_run: got %b%b required 10", err_b, run_b);
    end
    p = pops;
    rxq.push_back(8'h77); rxq.push_back(8'h88);
    repeat (10) @(negedge clk);
    checks++;
    if (pops !== p) begin errors++; $display("FAIL ovf_error_no_pop: got %0d pops required %0d", pops, p); end
    use_b = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    push_len(32'd2);
    rxq.push_back(8'h11); rxq.push_back(8'h22);
    for (n = 0; n < 200 && pops < 6; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (pops !== 6 || wa_n !== 0) begin
      errors++; $display("FAIL mid_before_rst: got pops=%0d writes=%0d required 6/0", pops, wa_n);
    end
    do_reset();
    push_len(32'd1);
    push_word(32'hCAFEBABE);
    finish_image();
    wait_ack(1'b0, "mid_ack");
    checks++;
    if (wa_n !== 1 || wa_addr[0] !== 8'h00 || wa_data[0] !== 32'hCAFEBABE) begin
      errors++; $display("FAIL mid_write: got n=%0d %h/%h required 1 00/cafebabe", wa_n, wa_addr[0], wa_data[0]);
    end
    checks++;
    if (ack_a_byte !== 8'hAA || err_a !== 1'b0) begin
      errors++; $display("FAIL mid_ack: got %h/%b required aa/0", ack_a_byte, err_a);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    push_len(32'd3);
    push_word(32'h00000001); push_word(32'h80000000); push_word(32'hA5A55A5A);
    finish_image();
    wait_ack(1'b0, "b2b_ack");
    checks++;
    if (dbl !== 0 || pops !== 16 + CS) begin
      errors++; $display("FAIL b2b_pop_spacing: got dbl=%0d pops=%0d required 0/%0d", dbl, pops, 16 + CS);
    end
    checks++;
    if (wa_n !== 3 || wa_data[2] !== 32'hA5A55A5A || wa_addr[2] !== 8'h02) begin
      errors++; $display("FAIL b2b_writes: got n=%0d %h/%h required 3 02/a5a55a5a", wa_n, wa_addr[2], wa_data[2]);
    end
    @(posedge clk); #2;
    core_next = 1'b1; core_tx_we = 1'b1; core_sdata = 8'h5A;
    #1;
    checks++;
    if ({next_a, tx_we_a} !== 2'b11 || sdata_a !== 8'h5A) begin
      errors++; $display("FAIL mux_on: got %b/%h required 11/5a", {next_a, tx_we_a}, sdata_a);
    end
    core_next = 1'b0; core_tx_we = 1'b0; core_sdata = 8'h3C;
    #1;
    checks++;
    if ({next_a, tx_we_a} !== 2'b00 || sdata_a !== 8'h3C) begin
      errors++; $display("FAIL mux_off: got %b/%h required 00/3c", {next_a, tx_we_a}, sdata_a);
    end
    core_sdata = 8'h00;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    do_reset();
    push_len(32'd1);
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'h04);
    rxq.push_back(8'h04);
    wait_ack(1'b0, "chk_ok_ack");
    checks++;
    if (ack_a_byte !== 8'hAA || run_a !== 1'b1 || wa_data[0] !== 32'h04030201) begin
      errors++; $display("FAIL chk_ok: got %h/%b/%h required aa/1/04030201", ack_a_byte, run_a, wa_data[0]);
    end
    do_reset();
    push_len(32'd1);
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'h04);
    rxq.push_back(8'h05);
    wait_ack(1'b0, "chk_bad_ack");
    checks++;
    if (ack_a_byte !== 8'h55 || err_a !== 1'b1 || run_a !== 1'b0) begin
      errors++; $display("FAIL chk_bad: got %h/%b/%b required 55/1/0", ack_a_byte, err_a, run_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load4();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
